serial_result_collector: RTL and testbench

//  Downstream stage of the bit-serial adder: captures the LSB-first serial sum stream plus final carry,

---
 rtl/serial_result_collector.sv | 131 +++++++++++++
 tb/tb_serial_result_collector.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_result_collector.sv
// Reassembles LSB-first serial sum frames (plus final carry) into parallel words and
// queues them in a small FIFO drained over a valid/ready handshake.
module serial_result_collector #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             frame_start,
    input  logic             sum_bit,
    input  logic             carry_bit,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_cout,
    output logic             res_zero,
    output logic             drop_pulse,
    output logic             frame_err,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = AW + 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [WIDTH-1:0]  shifted, first;
    logic              push, push_ok, pop, full;
    logic [WIDTH-1:0]  push_word;
    logic              err_d, drop_d;
    logic              err_q, drop_q;

    logic [WIDTH-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0]  cout_q;
    logic [AW-1:0]     wr_q, rd_q;
    logic [OW-1:0]     count_q, count_d, occ_after_pop;

    always_comb begin
        shifted            = shreg_q >> 1;
        shifted[WIDTH-1]   = sum_bit;
        first              = '0;
        first[WIDTH-1]     = sum_bit;
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        push_word = shifted;
        err_d     = 1'b0;
        if (bit_valid) begin
            if (frame_start) begin
                // A start bit always wins: mid-frame it aborts the partial word.
                err_d = (state_q == SHIFT);
                if (WIDTH == 1) begin
                    push      = 1'b1;
                    push_word = first;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    shreg_d = first;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end else if (state_q == SHIFT) begin
                shreg_d = shifted;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    push    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    // Fullness is judged after this edge's pop so a simultaneous pop frees a slot.
    always_comb begin
        pop           = res_valid && res_ready;
        occ_after_pop = count_q - OW'(pop);
        full          = (occ_after_pop == OW'(DEPTH));
        push_ok       = push && !full;
        drop_d        = push && full;
        count_d       = occ_after_pop + OW'(push_ok);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            cout_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            count_q <= count_d;
            if (push_ok) begin
                data_q[wr_q] <= push_word;
                cout_q[wr_q] <= carry_bit;
                wr_q         <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
            end
        end
    end

    assign res_valid  = (count_q != '0);
    assign res_data   = data_q[rd_q];
    assign res_cout   = cout_q[rd_q];
    assign res_zero   = res_valid && (res_data == '0) && !res_cout;
    assign drop_pulse = drop_q;
    assign frame_err  = err_q;
    assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_result_collector.sv
// Directed, table-driven self-check for serial_result_collector (WIDTH=8, DEPTH=2).
module tb_serial_result_collector;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bit_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic       sum_bit = 1'b0;
    logic       carry_bit = 1'b0;
    logic       res_ready = 1'b0;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_cout;
    logic       res_zero;
    logic       drop_pulse;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    serial_result_collector #(.WIDTH(8), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .frame_start(frame_start),
        .sum_bit(sum_bit), .carry_bit(carry_bit), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_cout(res_cout),
        .res_zero(res_zero), .drop_pulse(drop_pulse), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       cout;
        logic       gap;
        logic [7:0] exp_data;
        logic       exp_cout;
        logic       exp_zero;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic fs, input logic b, input logic c);
        bit_valid   = 1'b1;
        frame_start = fs;
        sum_bit     = b;
        carry_bit   = c;
        tick();
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        sum_bit     = 1'b0;
        carry_bit   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] w, input logic c, input logic gap);
        for (int i = 0; i < 8; i++) begin
            send_bit(i == 0, w[i], (i == 7) ? c : 1'b0);
            if (gap && i < 7) begin
                tick();
                if (i == 3) chk("gap_busy", busy, 1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[5] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0};

        // Reset state
        #1;
        chk("rst_valid", res_valid, 0);
        chk("rst_data", res_data, 0);
        chk("rst_cout", res_cout, 0);
        chk("rst_zero", res_zero, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Stray bits while idle are ignored
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1, 1'b1);
        chk("stray_busy", busy, 0);
        chk("stray_valid", res_valid, 0);
        chk("stray_err", frame_err, 0);

        // Table: single frames with consumer ready
        res_ready = 1'b1;
        foreach (vecs[k]) begin
            send_frame(vecs[k].data, vecs[k].cout, vecs[k].gap);
            chk("tbl_valid", res_valid, 1);
            chk("tbl_data", res_data, vecs[k].exp_data);
            chk("tbl_cout", res_cout, vecs[k].exp_cout);
            chk("tbl_zero", res_zero, vecs[k].exp_zero);
            chk("tbl_busy", busy, 0);
            tick();
            chk("tbl_popped", res_valid, 0);
        end

        // Two results held in order while not ready
        res_ready = 1'b0;
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h00, 1'b0, 1'b0);
        tick();
        chk("hold_valid", res_valid, 1);
        chk("hold_data0", res_data, 8'hFF);
        chk("hold_cout0", res_cout, 1);
        chk("hold_zero0", res_zero, 0);
        res_ready = 1'b1;
        tick();
        chk("hold_data1", res_data, 8'h00);
        chk("hold_zero1", res_zero, 1);
        chk("hold_valid1", res_valid, 1);
        tick();
        chk("hold_empty", res_valid, 0);
        res_ready = 1'b0;

        // Third frame into a full FIFO is dropped
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        chk("drop_none", drop_pulse, 0);
        send_frame(8'h33, 1'b0, 1'b0);
        chk("drop_pulse", drop_pulse, 1);
        tick();
        chk("drop_once", drop_pulse, 0);
        chk("drop_head", res_data, 8'h11);
        res_ready = 1'b1;
        tick();
        chk("drop_second", res_data, 8'h22);
        chk("drop_second_c", res_cout, 1);
        tick();
        chk("drop_drained", res_valid, 0);
        res_ready = 1'b0;

        // Pop on the last-bit edge makes room for the push
        send_frame(8'h44, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(i == 0, 1'(8'h66 >> i), 1'b0);
        res_ready = 1'b1;
        send_bit(1'b0, 1'b0, 1'b1);
        chk("fullpop_drop", drop_pulse, 0);
        chk("fullpop_head", res_data, 8'h55);
        tick();
        chk("fullpop_third", res_data, 8'h66);
        chk("fullpop_third_c", res_cout, 1);
        chk("fullpop_valid", res_valid, 1);
        tick();
        chk("fullpop_empty", res_valid, 0);
        res_ready = 1'b0;

        // frame_start mid-frame restarts and flags once
        for (int i = 0; i < 4; i++) send_bit(i == 0, 1'b1, 1'b0);
        chk("err_busy", busy, 1);
        chk("err_none", frame_err, 0);
        for (int i = 0; i < 8; i++) begin
            send_bit(i == 0, 1'(8'h81 >> i), 1'b0);
            if (i == 0) chk("err_pulse", frame_err, 1);
            if (i == 1) chk("err_once", frame_err, 0);
        end
        chk("err_valid", res_valid, 1);
        chk("err_data", res_data, 8'h81);
        res_ready = 1'b1;
        tick();
        chk("err_drained", res_valid, 0);
        res_ready = 1'b0;

        // Asynchronous reset mid-frame with a queued result
        send_frame(8'h77, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(i == 0, 1'b1, 1'b0);
        chk("prerst_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("arst_valid", res_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_data", res_data, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("arst_drop", drop_pulse, 0);
        chk("arst_err", frame_err, 0);
        res_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0);
        chk("arst_new_valid", res_valid, 1);
        chk("arst_new_data", res_data, 8'h3C);
        tick();
        chk("arst_new_pop", res_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
